// File: rtl/pwm_duty_sequencer.sv
// rtl/pwm_duty_sequencer.sv - button/breathe driven duty source for the 50-slot PWM generator
// Duty changes land only on a period boundary, flagged by a one-cycle pwm_reload pulse.

module pwm_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic sync_1;
  logic sync_2;
  logic level;
  logic level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_1  <= raw;
      sync_2  <= sync_1;
      level_q <= level;
      // any sample matching the accepted level restarts the stability window
      if (sync_2 != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync_2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_q;
endmodule

module pwm_duty_sequencer #(
  parameter int PERIOD          = 50,
  parameter int STEP            = 1,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int RAMP_DIV        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       mode,
  output logic [5:0] duty,
  output logic       pwm_reload,
  output logic       pending
);
  localparam int PW = $clog2(PERIOD);
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);
  localparam logic [RW-1:0] RAMP_LAST   = RW'(RAMP_DIV - 1);
  localparam logic [5:0]    PERIOD_6    = 6'(PERIOD);
  localparam logic [5:0]    STEP_6      = 6'(STEP);

  typedef enum logic [1:0] {IDLE, PENDING, RELOAD} state_t;

  state_t        state;
  logic [PW-1:0] period_cnt;
  logic [RW-1:0] ramp_cnt;
  logic [5:0]    target;
  logic          dir_up;
  logic          mode_s1;
  logic          mode_s2;
  logic          mode_q;
  logic          up_press;
  logic          down_press;
  logic          boundary;
  logic [6:0]    up_sum;
  logic [5:0]    up_sat;
  logic [5:0]    dn_sat;

  pwm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_up),
    .rise  (up_press)
  );

  pwm_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_down),
    .rise  (down_press)
  );

  assign boundary = (period_cnt == PERIOD_LAST);
  assign up_sum   = {1'b0, target} + {1'b0, STEP_6};
  assign up_sat   = (up_sum >= {1'b0, PERIOD_6}) ? PERIOD_6 : up_sum[5:0];
  assign dn_sat   = (target <= STEP_6) ? 6'd0 : (target - STEP_6);

  // the generator restarts its own count on reload, so follow it
  always_ff @(posedge clk) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (pwm_reload || boundary) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      mode_q  <= mode_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target   <= 6'd0;
      dir_up   <= 1'b1;
      ramp_cnt <= '0;
    end else if (mode_s2) begin
      if (!mode_q) begin
        dir_up   <= 1'b1;
        ramp_cnt <= '0;
      end else if (boundary) begin
        if (ramp_cnt == RAMP_LAST) begin
          ramp_cnt <= '0;
          if (dir_up) begin
            target <= up_sat;
            if (up_sat == PERIOD_6) dir_up <= 1'b0;
          end else begin
            target <= dn_sat;
            if (dn_sat == 6'd0) dir_up <= 1'b1;
          end
        end else begin
          ramp_cnt <= ramp_cnt + 1'b1;
        end
      end
    end else begin
      if (up_press && !down_press) begin
        target <= up_sat;
      end else if (down_press && !up_press) begin
        target <= dn_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      duty       <= 6'd0;
      pwm_reload <= 1'b0;
      pending    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pwm_reload <= 1'b0;
          if (target != duty) begin
            state   <= PENDING;
            pending <= 1'b1;
          end
        end
        PENDING: begin
          // a target that wandered back to duty needs no reload at all
          if (target == duty) begin
            state   <= IDLE;
            pending <= 1'b0;
          end else if (boundary) begin
            duty       <= target;
            pwm_reload <= 1'b1;
            pending    <= 1'b0;
            state      <= RELOAD;
          end
        end
        RELOAD: begin
          pwm_reload <= 1'b0;
          if (target != duty) begin
            state   <= PENDING;
            pending <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          pwm_reload <= 1'b0;
          pending    <= 1'b0;
        end
      endcase
    end
  end
endmodule
